// File: rtl/alu_pkg.sv
// Shared EX/MEM definitions: skid-buffer states, flag bit positions and the pipeline entry layout.
// The flags field of entry_t exists only when FLAGS_EN is defined.
package alu_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  localparam int ENTRY_N  = 32;
  localparam int ENTRY_RW = 4;

  // Entry layout at the default widths; the skid buffer mirrors it with its own parameters.
  typedef struct packed {
    logic [ENTRY_N-1:0]  result;
    logic [ENTRY_RW-1:0] rd;
    logic                regwrite;
    logic                memwrite;
`ifdef FLAGS_EN
    logic [3:0]          flags;
`endif
  } entry_t;

endpackage

// File: rtl/flag_gen.sv
// Derives {N,Z,C,V} for an ALU result; C and V pass straight through from the ALU.
module flag_gen
  import alu_pkg::*;
#(
  parameter int N = 32
) (
  input  logic [N-1:0] result,
  input  logic [1:0]   cv,
  output logic [3:0]   flags
);

  always_comb begin
    flags         = 4'b0000;
    flags[FLAG_N] = result[N-1];
    flags[FLAG_Z] = (result == '0);
    flags[FLAG_C] = cv[1];
    flags[FLAG_V] = cv[0];
  end

endmodule

// File: rtl/ex_mem_skid.sv
// Two-entry EX/MEM skid buffer: head entry drives the memory stage, skid entry absorbs one stall.
// Define FLAGS_EN to add per-entry {N,Z,C,V} storage and the out_flags port.
module ex_mem_skid
  import alu_pkg::*;
#(
  parameter int N  = 32,
  parameter int RW = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [N-1:0]  in_result,
  input  logic [RW-1:0] in_rd,
  input  logic          in_regwrite,
  input  logic          in_memwrite,
  input  logic [1:0]    in_cv,
  input  logic          flush,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [N-1:0]  out_result,
  output logic [RW-1:0] out_rd,
  output logic          out_regwrite,
`ifdef FLAGS_EN
  output logic          out_memwrite,
  output logic [3:0]    out_flags
`else
  output logic          out_memwrite
`endif
);

  typedef struct packed {
    logic [N-1:0]  result;
    logic [RW-1:0] rd;
    logic          regwrite;
    logic          memwrite;
`ifdef FLAGS_EN
    logic [3:0]    flags;
`endif
  } slot_t;

  state_t     state;
  state_t     state_next;
  slot_t      head;
  slot_t      skid;
  slot_t      in_entry;
  logic [3:0] in_flags;
  logic       accept;
  logic       emit;
  logic       head_load;
  logic       head_from_skid;
  logic       skid_load;

  // Handshakes decode from registered state only, so ready/valid never depend on the other side.
  assign in_ready  = (state != FULL);
  assign out_valid = (state != EMPTY);
  assign accept    = in_valid & in_ready;
  assign emit      = out_valid & out_ready;

  flag_gen #(.N(N)) u_flag_gen (
    .result (in_result),
    .cv     (in_cv),
    .flags  (in_flags)
  );

  always_comb begin
    in_entry          = '0;
    in_entry.result   = in_result;
    in_entry.rd       = in_rd;
    in_entry.regwrite = in_regwrite;
    in_entry.memwrite = in_memwrite;
`ifdef FLAGS_EN
    in_entry.flags    = in_flags;
`endif
  end

`ifndef FLAGS_EN
  logic unused_flags;
  assign unused_flags = ^in_flags;
`endif

  // Flush overrides everything, including any accept or emit in the same cycle.
  always_comb begin
    state_next     = state;
    head_load      = 1'b0;
    head_from_skid = 1'b0;
    skid_load      = 1'b0;
    case (state)
      EMPTY: begin
        if (accept) begin
          state_next = ONE;
          head_load  = 1'b1;
        end
      end
      ONE: begin
        if (accept && emit) begin
          head_load = 1'b1;
        end else if (accept) begin
          state_next = FULL;
          skid_load  = 1'b1;
        end else if (emit) begin
          state_next = EMPTY;
        end
      end
      FULL: begin
        if (emit) begin
          state_next     = ONE;
          head_from_skid = 1'b1;
        end
      end
      default: state_next = EMPTY;
    endcase
    if (flush) begin
      state_next     = EMPTY;
      head_load      = 1'b0;
      head_from_skid = 1'b0;
      skid_load      = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= EMPTY;
    end else begin
      state <= state_next;
    end
  end

  // Slots are never cleared on empty or flush; out_valid alone qualifies their contents.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head <= '0;
      skid <= '0;
    end else begin
      if (head_load) begin
        head <= in_entry;
      end else if (head_from_skid) begin
        head <= skid;
      end
      if (skid_load) begin
        skid <= in_entry;
      end
    end
  end

  assign out_result   = head.result;
  assign out_rd       = head.rd;
  assign out_regwrite = head.regwrite;
  assign out_memwrite = head.memwrite;
`ifdef FLAGS_EN
  assign out_flags    = head.flags;
`endif

endmodule

// File: tb/tb_ex_mem_skid.sv
// Directed self-checking bench for ex_mem_skid; flag checks are compiled in only with FLAGS_EN.
module tb_ex_mem_skid;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_result;
  logic [3:0]  in_rd;
  logic        in_regwrite;
  logic        in_memwrite;
  logic [1:0]  in_cv;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic [3:0]  out_rd;
  logic        out_regwrite;
  logic        out_memwrite;
`ifdef FLAGS_EN
  logic [3:0]  out_flags;
`endif

  int n_checks = 0;
  int n_pass   = 0;

  ex_mem_skid #(.N(32), .RW(4)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_result    (in_result),
    .in_rd        (in_rd),
    .in_regwrite  (in_regwrite),
    .in_memwrite  (in_memwrite),
    .in_cv        (in_cv),
    .flush        (flush),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_result   (out_result),
    .out_rd       (out_rd),
    .out_regwrite (out_regwrite),
`ifdef FLAGS_EN
    .out_memwrite (out_memwrite),
    .out_flags    (out_flags)
`else
    .out_memwrite (out_memwrite)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_output(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    n_checks++;
    assert (observed === expected) n_pass++;
    else $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
  endtask

  task automatic apply_stimulus(input logic valid, input logic [31:0] result, input logic [3:0] rd,
                                input logic regwrite, input logic memwrite, input logic [1:0] cv);
    in_valid    = valid;
    in_result   = result;
    in_rd       = rd;
    in_regwrite = regwrite;
    in_memwrite = memwrite;
    in_cv       = cv;
  endtask

  // Inputs change and outputs are sampled on the falling edge, half a cycle from the active edge.
  task automatic next_cycle();
    @(negedge clk);
  endtask

  initial begin
    rst_n     = 1'b0;
    flush     = 1'b0;
    out_ready = 1'b0;
    apply_stimulus(1'b0, 32'h0, 4'h0, 1'b0, 1'b0, 2'b00);
    #2;
    check_output("reset_out_valid", 64'(out_valid), 64'd0);
    check_output("reset_in_ready", 64'(in_ready), 64'd1);
    check_output("reset_out_result", 64'(out_result), 64'd0);
    check_output("reset_out_rd", 64'(out_rd), 64'd0);
    check_output("reset_out_regwrite", 64'(out_regwrite), 64'd0);
    check_output("reset_out_memwrite", 64'(out_memwrite), 64'd0);
`ifdef FLAGS_EN
    check_output("reset_out_flags", 64'(out_flags), 64'd0);
`endif
    next_cycle();
    rst_n = 1'b1;
    next_cycle();

    // Single transfer with one-cycle latency.
    out_ready = 1'b1;
    apply_stimulus(1'b1, 32'h0000_0005, 4'd3, 1'b1, 1'b0, 2'b00);
    next_cycle();
    check_output("first_out_valid", 64'(out_valid), 64'd1);
    check_output("first_out_result", 64'(out_result), 64'd5);
    check_output("first_out_rd", 64'(out_rd), 64'd3);
    check_output("first_out_regwrite", 64'(out_regwrite), 64'd1);
`ifdef FLAGS_EN
    check_output("first_out_flags", 64'(out_flags), 64'b0000);
`endif
    apply_stimulus(1'b0, 32'h0, 4'd0, 1'b0, 1'b0, 2'b00);
    next_cycle();
    check_output("drain_out_valid", 64'(out_valid), 64'd0);
    check_output("drain_in_ready", 64'(in_ready), 64'd1);

    // Zero result with carry, then negative result.
    apply_stimulus(1'b1, 32'h0000_0000, 4'd7, 1'b0, 1'b1, 2'b10);
    next_cycle();
    check_output("zero_out_memwrite", 64'(out_memwrite), 64'd1);
`ifdef FLAGS_EN
    check_output("zero_carry_flags", 64'(out_flags), 64'b0110);
`endif
    apply_stimulus(1'b1, 32'h8000_0000, 4'd8, 1'b0, 1'b0, 2'b00);
    next_cycle();
    check_output("neg_out_result", 64'(out_result), 64'h8000_0000);
`ifdef FLAGS_EN
    check_output("neg_flags", 64'(out_flags), 64'b1000);
`endif
    apply_stimulus(1'b0, 32'h0, 4'd0, 1'b0, 1'b0, 2'b00);
    next_cycle();
    check_output("neg_drain_valid", 64'(out_valid), 64'd0);

    // Stall: A and B fill the buffer, C waits, then drain in order.
    out_ready = 1'b0;
    apply_stimulus(1'b1, 32'hAAAA_0001, 4'd1, 1'b1, 1'b0, 2'b00);
    next_cycle();
    check_output("stall_a_valid", 64'(out_valid), 64'd1);
    check_output("stall_a_ready", 64'(in_ready), 64'd1);
    apply_stimulus(1'b1, 32'hBBBB_0002, 4'd2, 1'b1, 1'b0, 2'b00);
    next_cycle();
    check_output("stall_b_ready", 64'(in_ready), 64'd0);
    check_output("stall_b_head", 64'(out_result), 64'hAAAA_0001);
    apply_stimulus(1'b1, 32'hCCCC_0003, 4'd4, 1'b0, 1'b1, 2'b00);
    next_cycle();
    check_output("stall_c_ready", 64'(in_ready), 64'd0);
    check_output("stall_c_head_stable", 64'(out_result), 64'hAAAA_0001);
    check_output("stall_c_rd_stable", 64'(out_rd), 64'd1);
    out_ready = 1'b1;
    next_cycle();
    check_output("order_b_result", 64'(out_result), 64'hBBBB_0002);
    check_output("order_b_rd", 64'(out_rd), 64'd2);
    check_output("order_b_ready", 64'(in_ready), 64'd1);
    next_cycle();
    check_output("order_c_result", 64'(out_result), 64'hCCCC_0003);
    check_output("order_c_memwrite", 64'(out_memwrite), 64'd1);
    check_output("order_c_valid", 64'(out_valid), 64'd1);
    apply_stimulus(1'b0, 32'h0, 4'd0, 1'b0, 1'b0, 2'b00);
    next_cycle();
    check_output("order_drain_valid", 64'(out_valid), 64'd0);

    // Flush while full and the consumer is ready: nothing is emitted.
    out_ready = 1'b0;
    apply_stimulus(1'b1, 32'hDDDD_0004, 4'd5, 1'b1, 1'b0, 2'b00);
    next_cycle();
    apply_stimulus(1'b1, 32'hEEEE_0005, 4'd6, 1'b1, 1'b0, 2'b00);
    next_cycle();
    check_output("pre_flush_ready", 64'(in_ready), 64'd0);
    apply_stimulus(1'b0, 32'h0, 4'd0, 1'b0, 1'b0, 2'b00);
    flush     = 1'b1;
    out_ready = 1'b1;
    next_cycle();
    check_output("flush_out_valid", 64'(out_valid), 64'd0);
    check_output("flush_in_ready", 64'(in_ready), 64'd1);
    check_output("flush_head_kept", 64'(out_result), 64'hDDDD_0004);
    flush = 1'b0;
    next_cycle();
    check_output("post_flush_valid", 64'(out_valid), 64'd0);
    flush = 1'b1;
    apply_stimulus(1'b1, 32'h1234_5678, 4'd9, 1'b1, 1'b0, 2'b00);
    next_cycle();
    check_output("flush_beats_accept", 64'(out_valid), 64'd0);
    flush = 1'b0;

    // Streaming: one entry per cycle, each output is the previous cycle's input.
    for (int i = 0; i < 11; i++) begin
      apply_stimulus(1'b1, 32'h0000_0100 + 32'(i), 4'(i), 1'b1, 1'b0, 2'b00);
      next_cycle();
      check_output($sformatf("stream_result_%0d", i), 64'(out_result), 64'h100 + 64'(i));
      check_output($sformatf("stream_ready_%0d", i), 64'(in_ready), 64'd1);
    end
    apply_stimulus(1'b0, 32'h0, 4'd0, 1'b0, 1'b0, 2'b00);
    next_cycle();
    check_output("stream_drain_valid", 64'(out_valid), 64'd0);

    // Asynchronous reset while full, then a fresh transfer.
    out_ready = 1'b0;
    apply_stimulus(1'b1, 32'hF00D_0001, 4'd1, 1'b0, 1'b0, 2'b00);
    next_cycle();
    apply_stimulus(1'b1, 32'hF00D_0002, 4'd2, 1'b0, 1'b0, 2'b00);
    next_cycle();
    apply_stimulus(1'b0, 32'h0, 4'd0, 1'b0, 1'b0, 2'b00);
    check_output("pre_reset_full", 64'(in_ready), 64'd0);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_output("async_reset_valid", 64'(out_valid), 64'd0);
    check_output("async_reset_ready", 64'(in_ready), 64'd1);
    check_output("async_reset_result", 64'(out_result), 64'd0);
    #1;
    rst_n = 1'b1;
    next_cycle();
    apply_stimulus(1'b1, 32'h0000_0BEE, 4'd10, 1'b1, 1'b0, 2'b00);
    next_cycle();
    check_output("after_reset_result", 64'(out_result), 64'h0BEE);
    check_output("after_reset_ready", 64'(in_ready), 64'd1);
    check_output("after_reset_valid", 64'(out_valid), 64'd1);

    $display("[TB] %0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/ex_mem_skid.md
EX_MEM_SKID -- requirements
Module: ex_mem_skid

Interface
REQ-001 Parameter N, default 32, datapath width of the ALU result.
REQ-002 Parameter RW, default 4, width of the destination register index.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 in_valid  input  1  ALU stage presents a result this cycle.
REQ-006 in_ready  output  1  block can accept; equals (state != FULL).
REQ-007 in_result  input  N  ALU operation result (move, add, logic, ...).
REQ-008 in_rd  input  RW  destination register index.
REQ-009 in_regwrite  input  1  result is written to the register file.
REQ-010 in_memwrite  input  1  result is a store address or data.
REQ-011 in_cv  input  2  {C,V} from the ALU; 2'b00 for ops without carry/overflow.
REQ-012 flush  input  1  synchronous pipeline flush (branch taken).
REQ-013 out_valid  output  1  head entry valid for the memory stage.
REQ-014 out_ready  input  1  memory stage accepts the head entry.
REQ-015 out_result / out_rd / out_regwrite / out_memwrite  output  N / RW / 1 / 1  head entry fields.
REQ-016 out_flags  output  4  {N,Z,C,V} of the head entry; present only with FLAGS_EN.

Function
REQ-017 Two-entry skid buffer: accept = in_valid & in_ready; emit = out_valid & out_ready.
REQ-018 State machine EMPTY, ONE, FULL; out_valid = (state != EMPTY).
REQ-019 EMPTY: accept -> ONE; otherwise stays EMPTY.
REQ-020 ONE: accept without emit -> FULL; emit without accept -> EMPTY; both or neither -> ONE.
REQ-021 FULL: emit -> ONE (skid entry promoted to head); in_ready is 0, so no accept occurs.
REQ-022 Latency is one cycle: data accepted at edge k is on the out_* ports after edge k, with out_valid=1.
REQ-023 Ordering is strictly FIFO; no entry is dropped or duplicated except by flush.
REQ-024 In ONE with simultaneous accept and emit, the new entry becomes head on the same edge.
REQ-025 out_* fields hold the head entry and remain stable while out_valid=1 and out_ready=0.
REQ-026 Flags are computed at capture: N = in_result[N-1]; Z = (in_result == 0); C,V = in_cv.
REQ-027 When flush=1 at an edge, state becomes EMPTY and in-cycle accept and emit are discarded; flush has priority over every other event.
REQ-028 in_ready and out_valid are decoded from registered state only, with no combinational path from in_valid or out_ready.
REQ-029 Field registers of an empty slot are not cleared except by reset.

Reset
REQ-030 rst_n=0 forces state EMPTY immediately, regardless of clk.
REQ-031 Reset values: out_valid=0, in_ready=1, out_result=0, out_rd=0, out_regwrite=0, out_memwrite=0, out_flags=0.
REQ-032 Reset asserted mid-transfer discards both entries; first accept after release behaves as from EMPTY.

Configuration
REQ-033 Macro FLAGS_EN: when defined, out_flags port and per-entry 4-bit flag storage exist per REQ-026.
REQ-034 Without FLAGS_EN, out_flags port and flag storage are absent; all other behaviour is identical.

Structure
REQ-035 Shared package alu_pkg holds the state enum (EMPTY, ONE, FULL), flag bit index constants (FLAG_N=3, FLAG_Z=2, FLAG_C=1, FLAG_V=0) and the entry struct typedef {result, rd, regwrite, memwrite, flags}.
REQ-036 One sub-module, flag_gen, computes {N,Z,C,V} from result and cv; the skid buffer instantiates it at the input.

Verification
REQ-037 Reset, then in_valid=1, in_result=32'h0000_0005, in_rd=3, out_ready=1 -> next cycle out_valid=1, out_result=5, out_rd=3, out_flags=4'b0000.
REQ-038 in_result=0, in_cv=2'b10 -> out_flags=4'b0110; in_result=32'h8000_0000, in_cv=0 -> out_flags=4'b1000.
REQ-039 out_ready=0, three back-to-back in_valid writes A,B,C -> A and B accepted, in_ready=0 while C is held; with out_ready=1 the outputs are A, then B, then C, in order.
REQ-040 FULL with flush=1 and out_ready=1 on the same edge -> next cycle out_valid=0, in_ready=1, and no entry is emitted.
REQ-041 ONE with in_valid=1 and out_ready=1 for 10 cycles -> state stays ONE, throughput 1 per cycle, and each output equals the input from one cycle earlier.
REQ-042 rst_n pulsed low mid-cycle while FULL -> out_valid=0 and in_ready=1 immediately, before the next clk edge.
